// File: rtl/fir_coef_seq_if.sv
// fir_coef_seq_if: coefficient, sample and filter-control signals of the FIR sequencer
// master: host/source side (drives cfg_*, sample_valid, a_in)
// slave:  controller side (drives ready flags, a_out, strobes, coefficient chain, status)
interface fir_coef_seq_if #(
  parameter int COEF_W = 8,
  parameter int NTAPS  = 4,
  parameter int DATA_W = 8
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [NTAPS*COEF_W-1:0]   cfg_coefs;
  logic                      sample_valid;
  logic                      sample_ready;
  logic [DATA_W-1:0]         a_in;
  logic [DATA_W-1:0]         a_out;
  logic                      data_strobe;
  logic                      shiftIn;
  logic                      shiftClk1;
  logic                      busy;
  logic                      coef_valid;
  logic                      load_done;
  modport master (
    output cfg_valid, cfg_coefs, sample_valid, a_in,
    input  cfg_ready, sample_ready, a_out, data_strobe, shiftIn, shiftClk1, busy, coef_valid, load_done
  );
  modport slave (
    input  cfg_valid, cfg_coefs, sample_valid, a_in,
    output cfg_ready, sample_ready, a_out, data_strobe, shiftIn, shiftClk1, busy, coef_valid, load_done
  );
endinterface

// File: rtl/fir_coef_seq.sv
// fir_coef_seq: serializes a coefficient set onto the FIR shift chain and strobes samples into the filter
// ph1: clock, reset_n: async active-low reset
// bus.cfg_*: coefficient handshake, bus.sample_*/a_in/a_out/data_strobe: sample path
// bus.shiftIn/shiftClk1: coefficient chain, bus.busy/coef_valid/load_done: load status
module fir_coef_seq #(
  parameter int COEF_W    = 8,
  parameter int NTAPS     = 4,
  parameter int SHIFT_DIV = 2,
  parameter int DATA_W    = 8
) (
  input logic           ph1,
  input logic           reset_n,
  fir_coef_seq_if.slave bus
);
  localparam int W  = NTAPS * COEF_W;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, SETUP, CLOCK, DONE} state_t;
  state_t state, next;
  logic [W-1:0] sreg;
  logic [CW-1:0] cnt;
  logic [7:0] div;
  logic run;
  logic phase_end, accept, take;
  assign phase_end = div == 8'(SHIFT_DIV - 1);
  assign accept    = bus.cfg_valid & bus.cfg_ready;
  assign take      = bus.sample_valid & bus.sample_ready;
  always_ff @(posedge ph1 or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state == IDLE  ? (accept ? SETUP : IDLE) :
           state == SETUP ? (phase_end ? CLOCK : SETUP) :
           state == CLOCK ? (phase_end ? (cnt == '0 ? DONE : SETUP) : CLOCK) :
           IDLE;
  end
  // run holds ready low during reset and the first cycle after it
  always_comb begin
    bus.cfg_ready    = run & (state == IDLE);
    bus.sample_ready = run & (state == IDLE) & bus.coef_valid & ~bus.cfg_valid;
    bus.busy         = state != IDLE;
    bus.load_done    = state == DONE;
  end
  // shiftClk1/shiftIn are registered from next-state so the chain never sees decode glitches
  always_ff @(posedge ph1 or negedge reset_n)
    if (!reset_n) begin
      run             <= 1'b0;
      div             <= '0;
      sreg            <= '0;
      cnt             <= '0;
      bus.shiftIn     <= 1'b0;
      bus.shiftClk1   <= 1'b0;
      bus.coef_valid  <= 1'b0;
      bus.a_out       <= '0;
      bus.data_strobe <= 1'b0;
    end else begin
      run             <= 1'b1;
      div             <= next != state ? 8'd0 : div + 8'd1;
      bus.shiftClk1   <= next == CLOCK;
      bus.data_strobe <= take;
      if (take) bus.a_out <= bus.a_in;
      if (accept) begin
        sreg           <= bus.cfg_coefs;
        cnt            <= CW'(W - 1);
        bus.shiftIn    <= bus.cfg_coefs[W-1];
        bus.coef_valid <= 1'b0;
      end else if (state == CLOCK && next == SETUP) begin
        sreg        <= sreg << 1;
        cnt         <= cnt - 1'b1;
        bus.shiftIn <= sreg[W-2];
      end
      if (state == DONE) bus.coef_valid <= 1'b1;
    end
endmodule

// File: tb/tb_fir_coef_seq.sv
// tb_fir_coef_seq: checks fir_coef_seq against a cycle-count model plus directed literal expectations
module tb_fir_coef_seq;
  localparam int SD  = 2;
  localparam int LEN = 32 * 2 * SD + 1;
  logic ph1 = 0;
  logic reset_n = 0;
  always #5 ph1 = ~ph1;
  fir_coef_seq_if ia ();
  fir_coef_seq_if ib ();
  fir_coef_seq #(.SHIFT_DIV(SD)) dut  (.ph1(ph1), .reset_n(reset_n), .bus(ia.slave));
  fir_coef_seq #(.SHIFT_DIV(1))  dut1 (.ph1(ph1), .reset_n(reset_n), .bus(ib.slave));
  int total = 0;
  int bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  int m_t = -1;
  logic m_run = 0, m_cv = 0, m_stb = 0;
  logic [7:0] m_aout = 0;
  logic [31:0] m_word = 0;
  wire e_cr = m_run && m_t < 0;
  wire e_sr = e_cr && m_cv && !ia.cfg_valid;
  always @(posedge ph1 or negedge reset_n)
    if (!reset_n) begin
      m_run <= 0; m_t <= -1; m_cv <= 0; m_stb <= 0; m_aout <= 0;
    end else begin
      m_run <= 1;
      m_stb <= ia.sample_valid && e_sr;
      if (ia.sample_valid && e_sr) m_aout <= ia.a_in;
      if (m_t < 0) begin
        if (ia.cfg_valid && e_cr) begin m_t <= 0; m_word <= ia.cfg_coefs; m_cv <= 0; end
      end else if (m_t == LEN - 1) begin
        m_t <= -1; m_cv <= 1;
      end else m_t <= m_t + 1;
    end
  always @(negedge ph1) begin
    check("busy", ia.busy, m_t >= 0);
    check("shiftClk1", ia.shiftClk1, m_t >= 0 && m_t < LEN - 1 && ((m_t / SD) % 2 == 1));
    if (m_t >= 0 && m_t < LEN - 1) check("shiftIn", ia.shiftIn, m_word[31 - m_t / (2 * SD)]);
    check("load_done", ia.load_done, m_t == LEN - 1);
    check("coef_valid", ia.coef_valid, m_cv);
    check("cfg_ready", ia.cfg_ready, e_cr);
    check("sample_ready", ia.sample_ready, e_sr);
    check("data_strobe", ia.data_strobe, m_stb);
    check("a_out", ia.a_out, m_aout);
  end
  int cyc = 0, rises = 0, busy_cnt = 0, ld_cnt = 0, cur = 0;
  logic [31:0] rec = 0;
  logic psc = 0, pb = 0;
  logic [7:0] sq[$];
  int cq[$], runs[$], ldb[$], stb[$];
  always @(negedge ph1) begin
    cyc <= cyc + 1;
    if (ia.shiftClk1 && !psc) begin rises <= rises + 1; rec <= {rec[30:0], ia.shiftIn}; end
    psc <= ia.shiftClk1;
    busy_cnt <= busy_cnt + int'(ia.busy);
    ld_cnt <= ld_cnt + int'(ia.load_done);
    if (ia.data_strobe) begin sq.push_back(ia.a_out); cq.push_back(cyc); end
    if (ib.busy) cur <= cur + 1;
    else if (cur > 0) begin runs.push_back(cur); cur <= 0; end
    if (ib.load_done) ldb.push_back(cyc);
    if (ib.busy && !pb) stb.push_back(cyc);
    pb <= ib.busy;
  end
  task automatic step;
    @(posedge ph1);
    #1;
  endtask
  task automatic load(input logic [31:0] w);
    int r0, b0, l0, n;
    r0 = rises; b0 = busy_cnt; l0 = ld_cnt; n = 0;
    ia.cfg_coefs = w;
    ia.cfg_valid = 1;
    step;
    ia.cfg_valid = 0;
    while (!ia.coef_valid && n < 400) begin step; n++; end
    check("load timeout", n < 400, 1);
    check("rise count", rises - r0, 32);
    check("shifted word", rec, w);
    check("busy cycles", busy_cnt - b0, 129);
    check("load_done pulses", ld_cnt - l0, 1);
    check("coef_valid after load", ia.coef_valid, 1);
  endtask
  initial begin
    int s0, n;
    ia.cfg_valid = 0; ia.cfg_coefs = 0; ia.sample_valid = 1; ia.a_in = 8'h12;
    ib.cfg_valid = 0; ib.cfg_coefs = 0; ib.sample_valid = 0; ib.a_in = 0;
    repeat (3) @(posedge ph1);
    #2;
    check("rst busy", ia.busy, 0);
    check("rst cfg_ready", ia.cfg_ready, 0);
    check("rst sample_ready", ia.sample_ready, 0);
    check("rst shiftIn", ia.shiftIn, 0);
    check("rst shiftClk1", ia.shiftClk1, 0);
    check("rst coef_valid", ia.coef_valid, 0);
    check("rst a_out", ia.a_out, 0);
    reset_n = 1;
    repeat (4) step;
    check("no sample before coefs", ia.a_out, 0);
    check("no strobe before coefs", sq.size(), 0);
    ia.sample_valid = 0;
    load(32'h04030201);
    s0 = sq.size();
    ia.sample_valid = 1; ia.a_in = 8'h55;
    #1 check("sample_ready idle", ia.sample_ready, 1);
    step;
    ia.a_in = 8'hAA;
    step;
    ia.sample_valid = 0;
    step; step;
    check("strobe count", sq.size() - s0, 2);
    if (sq.size() - s0 == 2) begin
      check("first a_out", sq[s0], 8'h55);
      check("second a_out", sq[s0+1], 8'hAA);
      check("strobes consecutive", cq[s0+1] - cq[s0], 1);
    end
    ia.cfg_coefs = 32'hA5A5A5A5; ia.cfg_valid = 1; ia.sample_valid = 1; ia.a_in = 8'h77;
    #1;
    check("simul sample_ready", ia.sample_ready, 0);
    check("simul cfg_ready", ia.cfg_ready, 1);
    s0 = sq.size();
    step;
    ia.cfg_valid = 0; ia.sample_valid = 0;
    check("simul busy", ia.busy, 1);
    step;
    check("simul no strobe", sq.size() - s0, 0);
    repeat (84) step;
    check("busy before abort", ia.busy, 1);
    reset_n = 0;
    #1;
    check("abort shiftClk1", ia.shiftClk1, 0);
    check("abort busy", ia.busy, 0);
    check("abort coef_valid", ia.coef_valid, 0);
    step; step;
    reset_n = 1;
    step;
    check("coef_valid after abort", ia.coef_valid, 0);
    load(32'hFFFFFFFF);
    ib.cfg_coefs = 32'h0F0F0F0F;
    ib.cfg_valid = 1;
    n = 0;
    while (ldb.size() < 2 && n < 400) begin step; n++; end
    ib.cfg_valid = 0;
    check("sd1 timeout", n < 400, 1);
    repeat (4) step;
    check("sd1 loads", runs.size() >= 2, 1);
    if (runs.size() >= 2 && stb.size() >= 2) begin
      check("sd1 busy first", runs[0], 65);
      check("sd1 busy second", runs[1], 65);
      check("sd1 idle gap", stb[1] - ldb[0], 2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
